mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Sits between the per-thread LSUs and the data memory interface.
- Arbitrates NUM_CONSUMERS independent read/write request streams onto NUM_CHANNELS memory channels.
- Forwards each request, waits for the memory response, then relays ready (and read data) back to the requesting LSU.
- Holds that ready until the LSU withdraws its valid, then frees the channel.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 16, data word width
- NUM_CONSUMERS, 4, number of LSU request ports
- NUM_CHANNELS, 2, number of concurrent memory channels (must be ≤ NUM_CONSUMERS)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  per-LSU read done
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data
- consumer_write_ready  out  NUM_CONSUMERS  per-LSU write done
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address
- mem_read_ready  in  NUM_CHANNELS  channel read response valid
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  channel read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data
- mem_write_ready  in  NUM_CHANNELS  channel write acknowledge

Behaviour:
- Reset is synchronous and active-high. All outputs go to 0, every channel goes to IDLE, and the busy mask and per-channel current_consumer clear. A reset mid-transaction drops it silently; memory sees valid fall on the next edge.
- Per-channel FSM has five states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAY, WRITE_RELAY.
- IDLE: the channel scans consumers 0..NUM_CONSUMERS-1 and takes the lowest index that meets all of the following:
  - it has read_valid or write_valid asserted;
  - it is not in the busy mask;
  - it is not claimed in this same cycle by a lower-numbered channel.
  Channel 0 chooses first, so in one cycle distinct channels always pick distinct consumers.
- Read vs write on the same consumer: if both valids are high, the read is taken.
- On a read claim: register mem_read_valid=1 and mem_read_address=consumer address, set busy[i], go to READ_WAITING.
- On a write claim: the same, driving mem_write_valid, mem_write_address and mem_write_data; go to WRITE_WAITING.
- Issue latency: a consumer valid sampled high at edge T produces the memory valid at T+1.
- READ_WAITING: when mem_read_ready=1, clear mem_read_valid, set consumer_read_ready[i]=1, latch consumer_read_data[i]=mem_read_data, go to READ_RELAY. Response latency is 1 cycle from mem ready to consumer ready.
- WRITE_WAITING: when mem_write_ready=1, clear mem_write_valid, set consumer_write_ready[i]=1, go to WRITE_RELAY.
- RELAY states: hold ready (and read data) while the consumer's corresponding valid is sampled high. When it is sampled low, clear ready, clear busy[i] and return to IDLE. The consumer becomes claimable again one cycle after that.
- consumer_read_data[i] holds its last value after ready falls; it is not cleared.
- Waiting is unbounded: there is no timeout, and a channel waits indefinitely for memory ready.
- Arbitration is fixed priority. Starvation is acceptable because LSUs of one warp issue together and all complete before the next request.
- A consumer valid that drops while its request is still in a WAITING state is ignored until the response arrives; the relay then sees valid low and frees the channel in one cycle.

Test Plan:
- Single read: consumer 2 read_valid=1, addr 0x10; memory answers ready=1 with data 0x1234 two cycles after its valid. Required: mem_read_valid[0]=1 with addr 0x10 one cycle after the request; consumer_read_ready[2]=1 with data 0x1234 one cycle after mem ready; ready falls one cycle after the consumer drops valid.
- Contention: consumers 0, 1 and 3 assert read at once with NUM_CHANNELS=2. Required: channel 0 serves consumer 0, channel 1 serves consumer 1, and consumer 3 is issued on the first channel to return to IDLE.
- Single write: consumer 1 writes 0xBEEF to addr 0x22. Required: mem_write_valid, mem_write_address=0x22 and mem_write_data=0xBEEF are seen; consumer_write_ready[1] pulses after mem_write_ready; no read signals toggle.
- Read and write together: consumer 0 asserts both valids. Required: the read is issued first and the write is issued after the read relay completes.
- Reset mid-operation: assert reset while a channel is in READ_WAITING. Required: all outputs are 0 the next cycle, the busy mask is clear, and a fresh request is served normally after reset.
- Held ready: the consumer keeps valid high for 5 cycles after ready. Required: ready stays 1 for all of those cycles, and the channel is not reused until valid drops.

Source files
------------

// File: rtl/mem_controller.sv
// Arbitrates LSU read/write request ports onto a smaller set of memory channels.
// Each channel claims one consumer, forwards its request and relays the response back.
module mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAY,
        WRITE_RELAY
    } state_e;

    state_e                           state_q [NUM_CHANNELS];
    state_e                           state_d [NUM_CHANNELS];
    logic [CW-1:0]                    cur_q   [NUM_CHANNELS];
    logic [CW-1:0]                    cur_d   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]         busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]          mrv_q, mrv_d;
    logic [NUM_CHANNELS-1:0]          mwv_q, mwv_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mwa_q, mwa_d;
    logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]         crr_q, crr_d;
    logic [NUM_CONSUMERS-1:0]         cwr_q, cwr_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

    always_comb begin
        logic [NUM_CONSUMERS-1:0] claimed;
        logic                     found;
        logic [CW-1:0]            sel;
        busy_d  = busy_q;
        mrv_d   = mrv_q;
        mwv_d   = mwv_q;
        mra_d   = mra_q;
        mwa_d   = mwa_q;
        mwd_d   = mwd_q;
        crr_d   = crr_q;
        cwr_d   = cwr_q;
        crd_d   = crd_q;
        claimed = '0;
        found   = 1'b0;
        sel     = '0;
        // Channels are visited in index order so lower channels claim first.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            cur_d[ch]   = cur_q[ch];
            found       = 1'b0;
            sel         = '0;
            unique case (state_q[ch])
                IDLE: begin
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (!found && !busy_q[i] && !claimed[i] &&
                            (consumer_read_valid[i] || consumer_write_valid[i])) begin
                            found = 1'b1;
                            sel   = CW'(i);
                        end
                    end
                    if (found) begin
                        claimed[sel] = 1'b1;
                        busy_d[sel]  = 1'b1;
                        cur_d[ch]    = sel;
                        if (consumer_read_valid[sel]) begin
                            mrv_d[ch] = 1'b1;
                            mra_d[ch*ADDR_BITS +: ADDR_BITS] =
                                consumer_read_address[int'(sel)*ADDR_BITS +: ADDR_BITS];
                            state_d[ch] = READ_WAITING;
                        end else begin
                            mwv_d[ch] = 1'b1;
                            mwa_d[ch*ADDR_BITS +: ADDR_BITS] =
                                consumer_write_address[int'(sel)*ADDR_BITS +: ADDR_BITS];
                            mwd_d[ch*DATA_BITS +: DATA_BITS] =
                                consumer_write_data[int'(sel)*DATA_BITS +: DATA_BITS];
                            state_d[ch] = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mrv_d[ch]          = 1'b0;
                        crr_d[cur_q[ch]]   = 1'b1;
                        crd_d[int'(cur_q[ch])*DATA_BITS +: DATA_BITS] =
                            mem_read_data[ch*DATA_BITS +: DATA_BITS];
                        state_d[ch] = READ_RELAY;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mwv_d[ch]        = 1'b0;
                        cwr_d[cur_q[ch]] = 1'b1;
                        state_d[ch]      = WRITE_RELAY;
                    end
                end
                READ_RELAY: begin
                    if (!consumer_read_valid[cur_q[ch]]) begin
                        crr_d[cur_q[ch]]  = 1'b0;
                        busy_d[cur_q[ch]] = 1'b0;
                        state_d[ch]       = IDLE;
                    end
                end
                WRITE_RELAY: begin
                    if (!consumer_write_valid[cur_q[ch]]) begin
                        cwr_d[cur_q[ch]]  = 1'b0;
                        busy_d[cur_q[ch]] = 1'b0;
                        state_d[ch]       = IDLE;
                    end
                end
                default: begin
                    state_d[ch] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cur_q[ch]   <= '0;
            end
            busy_q <= '0;
            mrv_q  <= '0;
            mwv_q  <= '0;
            mra_q  <= '0;
            mwa_q  <= '0;
            mwd_q  <= '0;
            crr_q  <= '0;
            cwr_q  <= '0;
            crd_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            mrv_q   <= mrv_d;
            mwv_q   <= mwv_d;
            mra_q   <= mra_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            crr_q   <= crr_d;
            cwr_q   <= cwr_d;
            crd_q   <= crd_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_write_ready = cwr_q;
    assign consumer_read_data   = crd_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios plus randomized LSU/memory traffic
// compared every cycle against a job-level reference model.
module tb_mem_controller;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int NCON = 4;
    localparam int NCH  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [NCON-1:0]    crv, cwv, crr, cwr;
    logic [NCON*AW-1:0] craddr, cwaddr;
    logic [NCON*DW-1:0] cwdata, crd;
    logic [NCH-1:0]     mrv, mwv, mrr, mwr;
    logic [NCH*AW-1:0]  mra, mwa;
    logic [NCH*DW-1:0]  mrd, mwd;

    int checks   = 0;
    int failures = 0;

    int          fix_lat  = 2;
    bit          fix_on   = 1'b1;
    logic [DW-1:0] fix_data = 16'h1234;
    int          rcnt [NCH];
    int          rlat [NCH];

    mem_controller #(
        .ADDR_BITS(AW), .DATA_BITS(DW),
        .NUM_CONSUMERS(NCON), .NUM_CHANNELS(NCH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(crv),
        .consumer_read_address(craddr),
        .consumer_read_ready(crr),
        .consumer_read_data(crd),
        .consumer_write_valid(cwv),
        .consumer_write_address(cwaddr),
        .consumer_write_data(cwdata),
        .consumer_write_ready(cwr),
        .mem_read_valid(mrv),
        .mem_read_address(mra),
        .mem_read_ready(mrr),
        .mem_read_data(mrd),
        .mem_write_valid(mwv),
        .mem_write_address(mwa),
        .mem_write_data(mwd),
        .mem_write_ready(mwr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one job record per channel, ownership per consumer.
    int            m_kind  [NCH];
    bit            m_done  [NCH];
    int            m_cons  [NCH];
    logic [AW-1:0] m_addr  [NCH];
    logic [DW-1:0] m_wdata [NCH];
    logic [DW-1:0] m_rdata [NCON];
    int            m_owner [NCON];
    bit            model_on = 1'b0;

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_kind[ch] = 0;
            m_done[ch] = 1'b0;
            m_cons[ch] = 0;
        end
        for (int c = 0; c < NCON; c++) begin
            m_rdata[c] = '0;
            m_owner[c] = -1;
        end
    endtask

    task automatic model_step();
        int snap [NCON];
        bit claimed [NCON];
        bit found;
        bit hold;
        int p;
        for (int c = 0; c < NCON; c++) begin
            snap[c]    = m_owner[c];
            claimed[c] = 1'b0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_kind[ch] == 0) begin
                found = 1'b0;
                p     = 0;
                for (int i = 0; i < NCON; i++)
                    if (!found && (crv[i] || cwv[i]) && snap[i] < 0 && !claimed[i]) begin
                        found = 1'b1;
                        p     = i;
                    end
                if (found) begin
                    claimed[p] = 1'b1;
                    m_owner[p] = ch;
                    m_cons[ch] = p;
                    m_done[ch] = 1'b0;
                    if (crv[p]) begin
                        m_kind[ch] = 1;
                        m_addr[ch] = craddr[p*AW +: AW];
                    end else begin
                        m_kind[ch]  = 2;
                        m_addr[ch]  = cwaddr[p*AW +: AW];
                        m_wdata[ch] = cwdata[p*DW +: DW];
                    end
                end
            end else if (!m_done[ch]) begin
                if (m_kind[ch] == 1 && mrr[ch]) begin
                    m_done[ch] = 1'b1;
                    m_rdata[m_cons[ch]] = mrd[ch*DW +: DW];
                end
                if (m_kind[ch] == 2 && mwr[ch])
                    m_done[ch] = 1'b1;
            end else begin
                hold = (m_kind[ch] == 1) ? crv[m_cons[ch]] : cwv[m_cons[ch]];
                if (!hold) begin
                    m_owner[m_cons[ch]] = -1;
                    m_kind[ch] = 0;
                end
            end
        end
    endtask

    task automatic model_compare();
        logic [NCH-1:0]  e_mrv, e_mwv;
        logic [NCON-1:0] e_crr, e_cwr;
        e_mrv = '0;
        e_mwv = '0;
        e_crr = '0;
        e_cwr = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_kind[ch] == 1 && !m_done[ch]) e_mrv[ch] = 1'b1;
            if (m_kind[ch] == 2 && !m_done[ch]) e_mwv[ch] = 1'b1;
            if (m_kind[ch] == 1 && m_done[ch]) e_crr[m_cons[ch]] = 1'b1;
            if (m_kind[ch] == 2 && m_done[ch]) e_cwr[m_cons[ch]] = 1'b1;
        end
        chk("mdl_mem_read_valid", 64'(mrv), 64'(e_mrv));
        chk("mdl_mem_write_valid", 64'(mwv), 64'(e_mwv));
        chk("mdl_consumer_read_ready", 64'(crr), 64'(e_crr));
        chk("mdl_consumer_write_ready", 64'(cwr), 64'(e_cwr));
        for (int ch = 0; ch < NCH; ch++) begin
            if (e_mrv[ch])
                chk("mdl_mem_read_address", 64'(mra[ch*AW +: AW]), 64'(m_addr[ch]));
            if (e_mwv[ch]) begin
                chk("mdl_mem_write_address", 64'(mwa[ch*AW +: AW]), 64'(m_addr[ch]));
                chk("mdl_mem_write_data", 64'(mwd[ch*DW +: DW]), 64'(m_wdata[ch]));
            end
        end
        for (int c = 0; c < NCON; c++)
            chk("mdl_consumer_read_data", 64'(crd[c*DW +: DW]), 64'(m_rdata[c]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                model_reset();
                model_on = 1'b1;
            end else if (model_on) begin
                model_step();
            end
            #1;
            if (model_on) model_compare();
        end
    end

    // Memory responder: one-cycle ready pulse a few cycles after a channel valid.
    initial begin
        mrr = '0;
        mwr = '0;
        mrd = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rcnt[ch] = 0;
            rlat[ch] = 1;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (mrr[ch] || mwr[ch]) begin
                    mrr[ch]  = 1'b0;
                    mwr[ch]  = 1'b0;
                    rcnt[ch] = 0;
                end else if (mrv[ch] || mwv[ch]) begin
                    if (rcnt[ch] == 0)
                        rlat[ch] = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
                    rcnt[ch]++;
                    if (rcnt[ch] >= rlat[ch]) begin
                        if (mrv[ch]) begin
                            mrr[ch] = 1'b1;
                            mrd[ch*DW +: DW] = fix_on ? fix_data : DW'($urandom);
                        end else begin
                            mwr[ch] = 1'b1;
                        end
                    end
                end else begin
                    rcnt[ch] = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        crv = '0;
        cwv = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic random_traffic(input int cycles);
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < NCON; c++) begin
                if (crv[c]) begin
                    if (crr[c] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0))
                        crv[c] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    crv[c] = 1'b1;
                    craddr[c*AW +: AW] = AW'($urandom);
                end
                if (cwv[c]) begin
                    if (cwr[c] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0))
                        cwv[c] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    cwv[c] = 1'b1;
                    cwaddr[c*AW +: AW] = AW'($urandom);
                    cwdata[c*DW +: DW] = DW'($urandom);
                end
            end
        end
    endtask

    initial begin
        crv    = '0;
        cwv    = '0;
        craddr = '0;
        cwaddr = '0;
        cwdata = '0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single read on consumer 2, held for 5 cycles after ready.
        fix_data = 16'h1234;
        crv[2] = 1'b1;
        craddr[2*AW +: AW] = 8'h10;
        tick(1);
        chk("t1_mem_read_valid", 64'(mrv), 64'(2'b01));
        chk("t1_mem_read_addr", 64'(mra[7:0]), 64'(8'h10));
        chk("t1_ready_early", 64'(crr), 64'(4'b0000));
        tick(1);
        chk("t1_ready_wait", 64'(crr), 64'(4'b0000));
        tick(1);
        chk("t1_ready", 64'(crr), 64'(4'b0100));
        chk("t1_data", 64'(crd[47:32]), 64'(16'h1234));
        chk("t1_mem_valid_clr", 64'(mrv), 64'(2'b00));
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("t1_ready_held", 64'(crr), 64'(4'b0100));
            chk("t1_no_reissue", 64'(mrv), 64'(2'b00));
        end
        @(negedge clk);
        crv[2] = 1'b0;
        tick(1);
        chk("t1_ready_fall", 64'(crr), 64'(4'b0000));
        chk("t1_data_kept", 64'(crd[47:32]), 64'(16'h1234));
        settle(4);

        // Contention: consumers 0, 1, 3 read together.
        fix_data = 16'h0A0A;
        crv    = 4'b1011;
        craddr = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick(1);
        chk("t2_mem_read_valid", 64'(mrv), 64'(2'b11));
        chk("t2_ch0_addr", 64'(mra[7:0]), 64'(8'hA0));
        chk("t2_ch1_addr", 64'(mra[15:8]), 64'(8'hA1));
        tick(2);
        chk("t2_ready", 64'(crr), 64'(4'b0011));
        @(negedge clk);
        crv[1] = 1'b0;
        tick(1);
        chk("t2_ready_c1_fall", 64'(crr), 64'(4'b0001));
        chk("t2_no_issue_yet", 64'(mrv), 64'(2'b00));
        tick(1);
        chk("t2_c3_issue", 64'(mrv), 64'(2'b10));
        chk("t2_c3_addr", 64'(mra[15:8]), 64'(8'hA3));
        settle(8);

        // Single write on consumer 1.
        cwv[1] = 1'b1;
        cwaddr[AW +: AW] = 8'h22;
        cwdata[DW +: DW] = 16'hBEEF;
        tick(1);
        chk("t3_mem_write_valid", 64'(mwv), 64'(2'b01));
        chk("t3_write_addr", 64'(mwa[7:0]), 64'(8'h22));
        chk("t3_write_data", 64'(mwd[15:0]), 64'(16'hBEEF));
        chk("t3_no_read", 64'(mrv), 64'(2'b00));
        tick(2);
        chk("t3_write_ready", 64'(cwr), 64'(4'b0010));
        chk("t3_no_read_ready", 64'(crr), 64'(4'b0000));
        @(negedge clk);
        cwv[1] = 1'b0;
        tick(1);
        chk("t3_write_ready_fall", 64'(cwr), 64'(4'b0000));
        settle(4);

        // Read and write together on consumer 0: read first.
        fix_data = 16'h7777;
        crv[0] = 1'b1;
        cwv[0] = 1'b1;
        craddr[7:0]  = 8'h30;
        cwaddr[7:0]  = 8'h31;
        cwdata[15:0] = 16'h5555;
        tick(1);
        chk("t4_read_first", 64'(mrv), 64'(2'b01));
        chk("t4_no_write_yet", 64'(mwv), 64'(2'b00));
        chk("t4_read_addr", 64'(mra[7:0]), 64'(8'h30));
        tick(2);
        chk("t4_read_ready", 64'(crr), 64'(4'b0001));
        chk("t4_read_data", 64'(crd[15:0]), 64'(16'h7777));
        @(negedge clk);
        crv[0] = 1'b0;
        tick(1);
        chk("t4_read_ready_fall", 64'(crr), 64'(4'b0000));
        chk("t4_write_not_yet", 64'(mwv), 64'(2'b00));
        tick(1);
        chk("t4_write_issue", 64'(mwv), 64'(2'b01));
        chk("t4_write_addr", 64'(mwa[7:0]), 64'(8'h31));
        chk("t4_write_data", 64'(mwd[15:0]), 64'(16'h5555));
        tick(2);
        chk("t4_write_ready", 64'(cwr), 64'(4'b0001));
        settle(4);

        // Reset while channel 0 is waiting on memory.
        fix_data = 16'hC0DE;
        crv[2] = 1'b1;
        craddr[2*AW +: AW] = 8'h44;
        tick(1);
        chk("t5_issue", 64'(mrv), 64'(2'b01));
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        chk("t5_rst_mrv", 64'(mrv), 64'(2'b00));
        chk("t5_rst_mwv", 64'(mwv), 64'(2'b00));
        chk("t5_rst_crr", 64'(crr), 64'(4'b0000));
        chk("t5_rst_cwr", 64'(cwr), 64'(4'b0000));
        chk("t5_rst_crd", 64'(crd), 64'(0));
        chk("t5_rst_mra", 64'(mra), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        craddr[2*AW +: AW] = 8'h46;
        tick(1);
        chk("t5_fresh_issue", 64'(mrv), 64'(2'b01));
        chk("t5_fresh_addr", 64'(mra[7:0]), 64'(8'h46));
        tick(2);
        chk("t5_fresh_ready", 64'(crr), 64'(4'b0100));
        chk("t5_fresh_data", 64'(crd[47:32]), 64'(16'hC0DE));
        settle(4);

        // Randomized traffic with random memory latency and occasional resets.
        fix_lat = 0;
        fix_on  = 1'b0;
        random_traffic(4000);
        @(negedge clk);
        reset = 1'b0;
        settle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
